// File: rtl/axi_bridge_pkg.sv
// Shared types and constants for the core-side AXI memory bridge.
// Holds FSM states, AXI response codes, client IDs and default widths.
package axi_bridge_pkg;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_t;

  typedef enum logic {
    IF = 1'b0,
    LS = 1'b1
  } client_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
endpackage

// File: rtl/axi_mem_bridge_if.sv
// AXI single-beat channel bundle between the bridge and the SRAM slave.
// Modports are from the master and slave points of view.
interface axi_mem_bridge_if
  import axi_bridge_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready,
    output awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready,
    input  awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_bridge_arb.sv
// IF/LS grant logic; ARB_RR_EN selects round-robin, else LS over IF.
// The pointer register exists only in the round-robin build.
module axi_bridge_arb
  import axi_bridge_pkg::*;
(
  input  logic aclk,
  input  logic aresetn,
  input  logic idle,
  input  logic if_req,
  input  logic ls_req,
  output logic if_gnt,
  output logic ls_gnt
);
`ifdef ARB_RR_EN
  client_t ptr_q;

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (idle) begin
      unique case (1'b1)
        (if_req && !ls_req): if_gnt = 1'b1;
        (ls_req && !if_req): ls_gnt = 1'b1;
        (if_req && ls_req): begin
          if_gnt = (ptr_q == IF);
          ls_gnt = (ptr_q == LS);
        end
        default: ;
      endcase
    end
  end

  // Priority passes to the other client after every grant
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_q <= IF;
    end else if (if_gnt) begin
      ptr_q <= LS;
    end else if (ls_gnt) begin
      ptr_q <= IF;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = aclk ^ aresetn;

  always_comb begin
    ls_gnt = idle && ls_req;
    if_gnt = idle && if_req && !ls_req;
  end
`endif
endmodule

// File: rtl/axi_mem_bridge.sv
// IF/LS to single-beat AXI master bridge, one transaction in flight.
// Optional macro ARB_RR_EN enables round-robin arbitration.
module axi_mem_bridge
  import axi_bridge_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_ready,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_err,
  axi_mem_bridge_if.master    m
);
  state_t              state_q, state_d;
  client_t             owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                aw_done_q, w_done_q;
  logic                if_gnt, ls_gnt;
  logic                aw_fire, w_fire;
  logic                rd_done, wr_done;

  axi_bridge_arb u_arb (
    .aclk    (aclk),
    .aresetn (aresetn),
    .idle    (state_q == IDLE),
    .if_req  (if_req),
    .ls_req  (ls_req),
    .if_gnt  (if_gnt),
    .ls_gnt  (ls_gnt)
  );

  assign m.araddr = addr_q;
  assign m.awaddr = addr_q;
  assign m.wdata  = wdata_q;
  assign m.wstrb  = wstrb_q;

  assign aw_fire = (state_q == WR_REQ) && !aw_done_q && m.awready;
  assign w_fire  = (state_q == WR_REQ) && !w_done_q && m.wready;
  assign rd_done = (state_q == RD_DATA) && m.rvalid;
  assign wr_done = (state_q == WR_RESP) && m.bvalid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    if_ready  = 1'b0;
    ls_ready  = 1'b0;
    m.arvalid = 1'b0;
    m.rready  = 1'b0;
    m.awvalid = 1'b0;
    m.wvalid  = 1'b0;
    m.bready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if_ready = if_gnt;
        ls_ready = ls_gnt;
        if (ls_gnt) begin
          state_d = ls_we ? WR_REQ : RD_ADDR;
        end else if (if_gnt) begin
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        m.arvalid = 1'b1;
        if (m.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        m.rready = 1'b1;
        if (m.rvalid) state_d = IDLE;
      end
      WR_REQ: begin
        // Both channels start together; each drops after its own ready
        m.awvalid = !aw_done_q;
        m.wvalid  = !w_done_q;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        m.bready = 1'b1;
        if (m.bvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      owner_q   <= IF;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
      ls_err    <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if (ls_ready) begin
        owner_q   <= LS;
        addr_q    <= ls_addr;
        wdata_q   <= ls_wdata;
        wstrb_q   <= ls_wstrb;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else if (if_ready) begin
        owner_q <= IF;
        addr_q  <= if_addr;
      end
      if (aw_fire) aw_done_q <= 1'b1;
      if (w_fire)  w_done_q  <= 1'b1;
      if (rd_done && owner_q == LS) begin
        ls_rvalid <= 1'b1;
        ls_rdata  <= m.rdata;
        ls_err    <= (m.rresp != OKAY);
      end
      if (rd_done && owner_q == IF) begin
        if_rvalid <= 1'b1;
        if_rdata  <= m.rdata;
        if_err    <= (m.rresp != OKAY);
      end
      if (wr_done) begin
        ls_rvalid <= 1'b1;
        ls_rdata  <= '0;
        ls_err    <= (m.bresp != OKAY);
      end
    end
  end
endmodule

// File: tb/tb_axi_mem_bridge.sv
// Directed bench for axi_mem_bridge with a small SRAM-like AXI slave.
// Slave has a configurable wready delay and read response code.
module tb_axi_mem_bridge;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready, if_rvalid, if_err;
  logic [63:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [63:0] ls_wdata = '0;
  logic [7:0]  ls_wstrb = '0;
  logic        ls_ready, ls_rvalid, ls_err;
  logic [63:0] ls_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  axi_mem_bridge_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  axi_mem_bridge dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_wstrb  (ls_wstrb),
    .ls_ready  (ls_ready),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .ls_err    (ls_err),
    .m         (bus)
  );

  // ---------------- slave model ----------------
  logic [63:0] mem [256];
  logic [1:0]  r_resp_cfg = 2'b00;
  int          w_delay_cfg = 0;
  int          w_cnt;
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [63:0] pre_data = '0;
  logic        aw_got, w_got, aw_hs, w_hs, ar_hs, commit;
  logic [31:0] aw_a, c_addr;
  logic [63:0] w_d, c_data;
  logic [7:0]  w_s, c_strb;

  assign bus.arready = 1'b1;
  assign bus.awready = 1'b1;
  assign bus.wready  = (w_cnt >= w_delay_cfg);
  assign ar_hs  = bus.arvalid && bus.arready;
  assign aw_hs  = bus.awvalid && bus.awready;
  assign w_hs   = bus.wvalid && bus.wready;
  assign commit = (aw_got || aw_hs) && (w_got || w_hs);
  assign c_addr = aw_hs ? bus.awaddr : aw_a;
  assign c_data = w_hs ? bus.wdata : w_d;
  assign c_strb = w_hs ? bus.wstrb : w_s;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      bus.rresp  <= 2'b00;
      bus.bvalid <= 1'b0;
      bus.bresp  <= 2'b00;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      aw_a       <= '0;
      w_d        <= '0;
      w_s        <= '0;
      w_cnt      <= 0;
    end else begin
      if (ar_hs) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= mem[bus.araddr[10:3]];
        bus.rresp  <= r_resp_cfg;
      end else if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0;
      end
      if (aw_hs) aw_a <= bus.awaddr;
      if (w_hs) begin
        w_d <= bus.wdata;
        w_s <= bus.wstrb;
      end
      if (bus.wvalid && !bus.wready) w_cnt <= w_cnt + 1;
      else if (w_hs) w_cnt <= 0;
      if (commit) begin
        bus.bvalid <= 1'b1;
        bus.bresp  <= 2'b00;
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
    end
  end

  always @(posedge aclk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end else if (commit) begin
      for (int b = 0; b < 8; b++) begin
        if (c_strb[b]) mem[c_addr[10:3]][b*8 +: 8] <= c_data[b*8 +: 8];
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic nxt();
    @(posedge aclk);
    #1;
  endtask

  task automatic smp();
    @(negedge aclk);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    smp();
    n_cmp++;
    if ({if_ready, ls_ready, if_rvalid, ls_rvalid, if_err, ls_err} !== 6'b0) begin
      n_bad++;
      $display("FAIL rst_client got %b want 000000",
               {if_ready, ls_ready, if_rvalid, ls_rvalid, if_err, ls_err});
    end
    n_cmp++;
    if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_axi got %b want 00000",
               {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready});
    end
    n_cmp++;
    if ({bus.araddr, bus.wdata, if_rdata, ls_rdata} !== '0) begin
      n_bad++;
      $display("FAIL rst_data araddr %h wdata %h if_rdata %h ls_rdata %h want 0",
               bus.araddr, bus.wdata, if_rdata, ls_rdata);
    end
  endtask

  task automatic test_if_read();
    nxt();
    if_req  = 1'b1;
    if_addr = 32'h8000_0000;
    smp();
    n_cmp++;
    if (if_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ifrd_ready got %b want 1", if_ready);
    end
    nxt();
    if_req = 1'b0;
    smp();
    n_cmp++;
    if ({bus.arvalid, bus.araddr} !== {1'b1, 32'h8000_0000}) begin
      n_bad++;
      $display("FAIL ifrd_ar got %b/%h want 1/80000000", bus.arvalid, bus.araddr);
    end
    nxt();
    smp();
    nxt();
    smp();
    n_cmp++;
    if ({if_rvalid, if_err, if_rdata} !== {2'b10, 64'h1122334455667788}) begin
      n_bad++;
      $display("FAIL ifrd_resp got v%b e%b %h want v1 e0 1122334455667788",
               if_rvalid, if_err, if_rdata);
    end
  endtask

  task automatic test_ls_write();
    int cyc;
    nxt();
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 32'h8000_0010;
    ls_wdata = 64'h0000_0000_DEAD_BEEF;
    ls_wstrb = 8'h0F;
    smp();
    n_cmp++;
    if (ls_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL lswr_ready got %b want 1", ls_ready);
    end
    nxt();
    ls_req = 1'b0;
    ls_we  = 1'b0;
    smp();
    n_cmp++;
    if ({bus.awvalid, bus.wvalid} !== 2'b11) begin
      n_bad++;
      $display("FAIL lswr_awv_wv got %b want 11", {bus.awvalid, bus.wvalid});
    end
    nxt();
    smp();
    nxt();
    ls_req  = 1'b1;
    ls_addr = 32'h8000_0010;
    smp();
    n_cmp++;
    if ({ls_rvalid, ls_err, ls_rdata} !== {2'b10, 64'h0}) begin
      n_bad++;
      $display("FAIL lswr_pulse got v%b e%b %h want v1 e0 0", ls_rvalid, ls_err, ls_rdata);
    end
    n_cmp++;
    if (ls_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL lswr_accept_c3 got %b want 1", ls_ready);
    end
    cyc = -1;
    for (int c = 1; c <= 8; c++) begin
      nxt();
      ls_req = 1'b0;
      smp();
      if (ls_rvalid) begin
        cyc = c;
        break;
      end
    end
    n_cmp++;
    if (cyc != 3 || ls_rdata[31:0] !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL lswr_readback cycle %0d data %h want 3 / DEADBEEF", cyc, ls_rdata[31:0]);
    end
  endtask

  task automatic test_arbitration();
    logic exp_seq [4];
    logic got_seq [4];
    int   got;
`ifdef ARB_RR_EN
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h8000_0000;
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 32'h8000_0010;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      smp();
      if (if_ready || ls_ready) begin
        n_cmp++;
        if ((if_ready && ls_ready) !== 1'b0) begin
          n_bad++;
          $display("FAIL arb_onehot got if%b ls%b want one ready", if_ready, ls_ready);
        end
        got_seq[got] = ls_ready;
        got++;
      end
      nxt();
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    n_cmp++;
    if (got != 4) begin
      n_bad++;
      $display("FAIL arb_timeout grants %0d want 4", got);
    end
    for (int i = 0; i < got; i++) begin
      n_cmp++;
      if (got_seq[i] !== exp_seq[i]) begin
        n_bad++;
        $display("FAIL arb_grant%0d got ls=%b want ls=%b", i, got_seq[i], exp_seq[i]);
      end
    end
    repeat (6) nxt();
  endtask

  task automatic test_w_delay();
    int aw_n, w_n, p_n, p_cyc;
    w_delay_cfg = 3;
    nxt();
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 32'h8000_0020;
    ls_wdata = 64'h0123_4567_89AB_CDEF;
    ls_wstrb = 8'hFF;
    smp();
    n_cmp++;
    if (ls_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wdly_ready got %b want 1", ls_ready);
    end
    aw_n = 0;
    w_n = 0;
    p_n = 0;
    p_cyc = -1;
    for (int c = 1; c <= 10; c++) begin
      nxt();
      ls_req = 1'b0;
      ls_we  = 1'b0;
      smp();
      if (bus.awvalid) aw_n++;
      if (bus.wvalid) w_n++;
      if (ls_rvalid) begin
        p_n++;
        p_cyc = c;
      end
    end
    w_delay_cfg = 0;
    n_cmp++;
    if (aw_n != 1 || w_n != 4) begin
      n_bad++;
      $display("FAIL wdly_valids aw %0d w %0d want 1 / 4", aw_n, w_n);
    end
    n_cmp++;
    if (p_n != 1 || p_cyc != 6) begin
      n_bad++;
      $display("FAIL wdly_pulse count %0d cycle %0d want 1 / 6", p_n, p_cyc);
    end
  endtask

  task automatic test_rresp_err();
    int cyc;
    r_resp_cfg = 2'b10;
    nxt();
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 32'h8000_0020;
    cyc = -1;
    for (int c = 0; c <= 8; c++) begin
      smp();
      if (ls_rvalid) begin
        cyc = c;
        break;
      end
      nxt();
      ls_req = 1'b0;
    end
    r_resp_cfg = 2'b00;
    n_cmp++;
    if (cyc != 3 || ls_err !== 1'b1 || ls_rdata !== 64'h0123_4567_89AB_CDEF) begin
      n_bad++;
      $display("FAIL rerr_pulse cycle %0d err %b data %h want 3 / 1 / 0123456789abcdef",
               cyc, ls_err, ls_rdata);
    end
    nxt();
    if_req  = 1'b1;
    if_addr = 32'h8000_0000;
    smp();
    n_cmp++;
    if (if_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rerr_idle if_ready got %b want 1", if_ready);
    end
    nxt();
    if_req = 1'b0;
    repeat (2) nxt();
    smp();
    n_cmp++;
    if ({if_rvalid, if_err} !== 2'b10) begin
      n_bad++;
      $display("FAIL rerr_next got v%b e%b want v1 e0", if_rvalid, if_err);
    end
  endtask

  task automatic test_reset_mid();
    int pulses, cyc;
    nxt();
    if_req  = 1'b1;
    if_addr = 32'h8000_0000;
    smp();
    nxt();
    if_req = 1'b0;
    nxt();
    #1;
    n_cmp++;
    if (bus.rready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_in_rd_data rready got %b want 1", bus.rready);
    end
    aresetn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.arvalid, bus.rready, if_rvalid, ls_rvalid} !== 4'b0) begin
      n_bad++;
      $display("FAIL rstmid_drop got %b want 0000",
               {bus.arvalid, bus.rready, if_rvalid, ls_rvalid});
    end
    nxt();
    aresetn = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      smp();
      if (if_rvalid || ls_rvalid) pulses++;
      nxt();
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL rstmid_no_pulse got %0d want 0", pulses);
    end
    if_req  = 1'b1;
    if_addr = 32'h8000_0000;
    cyc = -1;
    for (int c = 0; c <= 8; c++) begin
      smp();
      if (if_rvalid) begin
        cyc = c;
        break;
      end
      nxt();
      if_req = 1'b0;
    end
    n_cmp++;
    if (cyc != 3 || if_rdata !== 64'h1122_3344_5566_7788) begin
      n_bad++;
      $display("FAIL rstmid_next cycle %0d data %h want 3 / 1122334455667788", cyc, if_rdata);
    end
  endtask

  initial begin
    @(posedge aclk);
    #1;
    pre_we   = 1'b1;
    pre_idx  = 8'd0;
    pre_data = 64'h1122_3344_5566_7788;
    @(posedge aclk);
    #1;
    pre_we = 1'b0;
    test_reset();
    test_if_read();
    test_ls_write();
    test_w_delay();
    test_rresp_err();
    test_reset_mid();
    test_arbitration();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
